// File: rtl/stopwatch_pkg.sv
// Shared state encoding and divider helpers for the stopwatch/timer.
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width needed to hold prescaler values 0..DIV-1.
  function automatic int presc_width(input int clk_hz, input int tick_hz);
    int div;
    div = clk_hz / tick_hz;
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_timer_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the last cycle of each interval.
`default_nettype none

module tick_gen
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = presc_width(DIV, 1);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  // Holding while disabled preserves the partial interval across a pause.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

  assign tick = en & ~rst & ~clr & (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/stopwatch_timer.sv
// Stopwatch / countdown timer: run-pause FSM, count, lap capture and overflow flag.
`default_nettype none

module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] lap_count,
  output logic             lap_valid,
  output logic             tick,
  output logic             running,
  output logic             expired,
  output logic             ovf
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

  state_t state, state_nxt;
  logic   mode_q;
  logic   presc_en;
  logic   presc_clr;
  logic   reach_zero;
  logic   start_idle;

  assign start_idle = (state == IDLE) & start_stop;
  assign presc_en   = (state == RUN);
  assign presc_clr  = clear | start_idle;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  assign reach_zero = mode_q & tick & (count == WIDTH'(1));

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_stop) state_nxt = (mode && load_val == '0) ? DONE : RUN;
        RUN: begin
          // Hitting zero wins over a coincident pause request.
          if (reach_zero)      state_nxt = DONE;
          else if (start_stop) state_nxt = PAUSE;
        end
        PAUSE: if (start_stop) state_nxt = RUN;
        DONE:  state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count     <= '0;
      lap_count <= '0;
      lap_valid <= 1'b0;
      ovf       <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      if (start_idle) begin
        mode_q <= mode;
        if (mode) count <= load_val;
      end
      // Lap samples the value before any same-edge count update.
      if ((state == RUN || state == PAUSE) && lap) begin
        lap_count <= count;
        lap_valid <= 1'b1;
      end
      if (tick) begin
        if (mode_q) begin
          count <= count - WIDTH'(1);
        end else begin
          count <= count + WIDTH'(1);
          if (&count) ovf <= 1'b1;
        end
      end
    end
  end

  assign running = (state == RUN);
  assign expired = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_timer.sv
// Randomized self-checking bench for stopwatch_timer against an elapsed-time reference model.
`default_nettype none

module tb_stopwatch_timer;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int WIDTH   = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MODV    = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_stop = 1'b0;
  logic             clear = 1'b0;
  logic             lap = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] lap_count;
  logic             lap_valid;
  logic             tick;
  logic             running;
  logic             expired;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .mode       (mode),
    .load_val   (load_val),
    .count      (count),
    .lap_count  (lap_count),
    .lap_valid  (lap_valid),
    .tick       (tick),
    .running    (running),
    .expired    (expired),
    .ovf        (ovf)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase plus total cycles spent running since the start.
  // 0 = idle, 1 = run, 2 = pause, 3 = done.
  int m_phase  = 0;
  int m_runcyc = 0;
  int m_load   = 0;
  bit m_down   = 0;
  bit m_lapv   = 0;
  int m_lap    = 0;

  function automatic int m_ticks();
    return m_runcyc / DIV;
  endfunction

  function automatic int m_count();
    if (m_down) return m_load - m_ticks();
    return m_ticks() % MODV;
  endfunction

  function automatic int m_ovf();
    return (!m_down && m_ticks() >= MODV) ? 1 : 0;
  endfunction

  function automatic int m_tick_now();
    return (m_phase == 1 && !rst && !clear && (m_runcyc % DIV == DIV - 1)) ? 1 : 0;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_runcyc = 0; m_load = 0; m_down = 0; m_lapv = 0; m_lap = 0;
  endtask

  task automatic m_edge();
    int cnow;
    if (rst || clear) begin
      m_reset();
    end else begin
      cnow = m_count();
      if (lap && (m_phase == 1 || m_phase == 2)) begin
        m_lap  = cnow;
        m_lapv = 1;
      end
      case (m_phase)
        0: if (start_stop) begin
          m_down   = mode;
          m_load   = mode ? int'(load_val) : 0;
          m_runcyc = 0;
          m_phase  = (mode && load_val == 0) ? 3 : 1;
        end
        1: begin
          m_runcyc++;
          if (m_down && m_count() == 0) m_phase = 3;
          else if (start_stop)          m_phase = 2;
        end
        2: if (start_stop) m_phase = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit c, input bit s, input bit l,
                      input bit m, input int lv);
    @(negedge clk);
    rst = r; clear = c; start_stop = s; lap = l; mode = m; load_val = WIDTH'(lv);
    #1;
    check("tick", int'(tick), m_tick_now());
    @(posedge clk);
    m_edge();
    #1;
    check("count",     int'(count),     m_count());
    check("lap_count", int'(lap_count), m_lap);
    check("lap_valid", int'(lap_valid), int'(m_lapv));
    check("running",   int'(running),   (m_phase == 1) ? 1 : 0);
    check("expired",   int'(expired),   (m_phase == 3) ? 1 : 0);
    check("ovf",       int'(ovf),       m_ovf());
  endtask

  initial begin
    // Reset, then up-count start; count must read 1 exactly after edge 10.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
    check("first_tick_count", int'(count), 1);
    // Run through a wrap to exercise the sticky overflow flag.
    for (int i = 0; i < 160; i++) step(0, 0, 0, (i % 37) == 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);
    // clear beats start_stop and lap in the same cycle.
    step(0, 1, 1, 1, 0, 0);
    // Countdown from 3, then a start_stop that must be ignored in DONE.
    step(0, 0, 1, 0, 1, 3);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 9);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // Zero load goes straight to DONE.
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // Reset mid-run, and reset together with clear and start_stop.
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 36; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 5);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 400) == 0,
           ($urandom % 250) == 0,
           ($urandom % 14) == 0,
           ($urandom % 9) == 0,
           1'($urandom % 2),
           int'($urandom_range(0, 6)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_timer.md
STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

Interface
REQ-001 The block SHALL provide parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 The block SHALL provide parameter TICK_HZ, default 1, count resolution in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2, integer.
REQ-003 The block SHALL provide parameter WIDTH, default 13, count width in bits.
REQ-004 The block SHALL have port clk, input, 1, single clock for all logic, rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 The block SHALL have port start_stop, input, 1, one-cycle pulse that toggles run/pause.
REQ-007 The block SHALL have port clear, input, 1, one-cycle pulse that returns to IDLE.
REQ-008 The block SHALL have port lap, input, 1, one-cycle pulse that captures a split.
REQ-009 The block SHALL have port mode, input, 1, 0 = count up, 1 = count down (timer).
REQ-010 The block SHALL have port load_val, input, WIDTH, countdown start value.
REQ-011 The block SHALL have port count, output, WIDTH, current count.
REQ-012 The block SHALL have port lap_count, output, WIDTH, last captured split.
REQ-013 The block SHALL have port lap_valid, output, 1, high once a split has been captured since clear.
REQ-014 The block SHALL have port tick, output, 1, one-cycle pulse on each count update.
REQ-015 The block SHALL have ports running, expired and ovf, each output, 1: state is RUN; state is DONE; up-count wrap seen since clear.

Function
REQ-016 The FSM SHALL have four states, IDLE, RUN, PAUSE and DONE, with all transitions on clk rising edge.
REQ-017 In IDLE, start_stop SHALL move the FSM to RUN and latch mode. In down mode it SHALL also load count with load_val. If load_val == 0, the FSM SHALL instead go directly to DONE.
REQ-018 In RUN, start_stop SHALL move the FSM to PAUSE; in PAUSE, start_stop SHALL move it back to RUN.
REQ-019 In DONE, start_stop SHALL be ignored.
REQ-020 clear SHALL move the FSM from any state to IDLE, with count=0, lap_count=0, lap_valid=0, ovf=0 and prescaler=0.
REQ-021 clear SHALL take priority over start_stop and lap in the same cycle.
REQ-022 The prescaler SHALL count 0..DIV-1 only in RUN. It SHALL hold its value in PAUSE, so the fractional interval is kept, and SHALL be zeroed on entry to RUN from IDLE.
REQ-023 tick SHALL pulse for exactly the cycle in which the prescaler equals DIV-1 in RUN. count SHALL update on the same edge that ends that cycle.
REQ-024 First tick latency SHALL be exactly DIV cycles after the start_stop cycle from IDLE.
REQ-025 In up mode, count SHALL increment by 1 modulo 2^WIDTH. On the wrap from all-ones to 0, ovf SHALL be set and remain sticky until clear or rst.
REQ-026 In down mode, count SHALL decrement by 1. When count reaches 0, the FSM SHALL enter DONE on the same edge, expired=1, and count SHALL hold at 0.
REQ-027 lap in RUN or PAUSE SHALL copy count into lap_count on the next edge and set lap_valid. lap in IDLE or DONE SHALL be ignored.
REQ-028 If lap coincides with a count update, lap_count SHALL capture the pre-update value.
REQ-029 mode and load_val SHALL be ignored outside IDLE.
REQ-030 running SHALL equal (state == RUN), and expired SHALL equal (state == DONE), both registered-state decodes.

Reset
REQ-031 rst SHALL be synchronous and active-high, and SHALL override all inputs including clear.
REQ-032 On rst the block SHALL set state=IDLE, count=0, lap_count=0, lap_valid=0, tick=0, ovf=0, prescaler=0 and latched mode=0.
REQ-033 rst asserted mid-RUN SHALL abort with no tick emitted in the reset cycle.

Structure
REQ-034 Package stopwatch_pkg SHALL hold the state typedef/encoding (IDLE, RUN, PAUSE, DONE) and a constant function computing DIV and the prescaler width from CLK_HZ and TICK_HZ.
REQ-035 The prescaler SHALL be a sub-module tick_gen with ports clk, rst, en, clr and tick. Its parameter is DIV.
REQ-036 All FSM, count and lap logic SHALL be in stopwatch_timer.

Verification (CLK_HZ=10, TICK_HZ=1, so DIV=10; WIDTH=4 unless noted)
REQ-037 Up count: rst, then start_stop at cycle 0 -> first tick in cycle 9, count=1 after edge 10, count=5 after 50 cycles.
REQ-038 Pause/resume: pause at cycle 25 (prescaler=5), hold 30 cycles, resume -> next tick after 4 more cycles, count 2->3, no tick while paused.
REQ-039 Wrap: up mode, run 160 cycles -> count 15 -> 0, ovf=1 and stays set; clear -> ovf=0, count=0, IDLE.
REQ-040 Countdown: mode=1, load_val=3, start -> count 3,2,1,0 at ticks, expired=1 after edge 30, start_stop ignored. load_val=0 -> DONE on the next edge.
REQ-041 Lap and priority: lap coinciding with tick at count 4->5 -> lap_count=4, lap_valid=1. clear+start_stop+lap in the same cycle -> IDLE, lap_valid=0.
REQ-042 Reset mid-run: rst at cycle 37 -> all outputs reset next edge, no tick. rst together with clear and start_stop -> IDLE.
